// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg
// Shared control encodings for the multicycle RV32I core: opcode constants,
// ImmSrc codes (also consumed by the immediate extender), datapath mux/ALU
// encodings and the controller state enum.
package riscv_ctrl_pkg;

    // Supported opcodes (instruction[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Result mux
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU operand A mux
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    // ALU operand B mux
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ALU op class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JALR,
        S_JAL,
        S_LUI
    } state_t;

endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder
// Combinational helpers for the controller: immediate-format select from the
// opcode and branch-condition evaluation from funct3 and the ALU flags.
// Ports:
//   i_opcode  - instruction[6:0]
//   i_funct3  - instruction[14:12]
//   i_zero    - ALU result == 0
//   i_lt      - ALU signed less-than
//   o_imm_src - immediate format code
//   o_taken   - branch condition satisfied
module ctrl_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_zero,
    input  logic       i_lt,
    output logic [2:0] o_imm_src,
    output logic       o_taken
);

    always_comb begin
        o_imm_src = IMM_I;
        case (i_opcode)
            OP_STORE:  o_imm_src = IMM_S;
            OP_BRANCH: o_imm_src = IMM_B;
            OP_JAL:    o_imm_src = IMM_J;
            OP_LUI:    o_imm_src = IMM_U;
            default:   o_imm_src = IMM_I;
        endcase
    end

    // Unsupported funct3 values simply fall through (never taken).
    always_comb begin
        o_taken = 1'b0;
        case (i_funct3)
            3'b000:  o_taken = i_zero;
            3'b001:  o_taken = ~i_zero;
            3'b100:  o_taken = i_lt;
            3'b101:  o_taken = ~i_lt;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Main Moore control FSM for the multicycle RV32I core. Sequences each
// instruction through fetch/decode/execute/memory/writeback and drives the
// shared datapath's mux selects, write enables and ALU op class.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   opcode, funct3     - fields from the instruction register
//   zero, lt           - ALU flags, used during BRANCH only
//   PCWrite .. RegWrite- write enables / address select
//   ResultSrc, ALUSrcA, ALUSrcB, ALUOp - datapath selects
//   ImmSrc             - immediate format (combinational from opcode)
//   illegal            - one-cycle pulse in DECODE on an unsupported opcode
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       illegal
);

    state_t r_state;
    state_t w_next_state;
    logic   w_pc_update;
    logic   w_branch;
    logic   w_taken;

    ctrl_decoder u_dec (
        .i_opcode  (opcode),
        .i_funct3  (funct3),
        .i_zero    (zero),
        .i_lt      (lt),
        .o_imm_src (ImmSrc),
        .o_taken   (w_taken)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = S_FETCH;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        AdrSrc       = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        ResultSrc    = RES_ALUOUT;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_RD2;
        ALUOp        = ALUOP_ADD;
        illegal      = 1'b0;

        case (r_state)
            S_FETCH: begin
                IRWrite      = 1'b1;
                ALUSrcA      = SRCA_PC;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURESULT;
                w_pc_update  = 1'b1;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                // Branch/JAL target is precomputed into ALUOut here.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                    OP_RTYPE:          w_next_state = S_EXECR;
                    OP_ITYPE:          w_next_state = S_EXECI;
                    OP_BRANCH:         w_next_state = S_BRANCH;
                    OP_JAL:            w_next_state = S_JAL;
                    OP_JALR:           w_next_state = S_JALR;
                    OP_LUI:            w_next_state = S_LUI;
                    default: begin
                        illegal      = 1'b1;
                        w_next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA      = SRCA_RD1;
                ALUSrcB      = SRCB_IMM;
                w_next_state = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc       = 1'b1;
                w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc    = RES_MEMDATA;
                RegWrite     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc       = 1'b1;
                MemWrite     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA      = SRCA_RD1;
                ALUSrcB      = SRCB_RD2;
                ALUOp        = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA      = SRCA_RD1;
                ALUSrcB      = SRCB_IMM;
                ALUOp        = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA      = SRCA_RD1;
                ALUSrcB      = SRCB_RD2;
                ALUOp        = ALUOP_SUB;
                w_branch     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JALR: begin
                // Computes rs1+imm; JAL then links and loads the PC from it.
                ALUSrcA      = SRCA_RD1;
                ALUSrcB      = SRCB_IMM;
                w_next_state = S_JAL;
            end
            S_JAL: begin
                ALUSrcA      = SRCA_OLDPC;
                ALUSrcB      = SRCB_FOUR;
                w_pc_update  = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA      = SRCA_ZERO;
                ALUSrcB      = SRCB_IMM;
                w_next_state = S_ALUWB;
            end
            default: w_next_state = S_FETCH;
        endcase

        PCWrite = w_pc_update | (w_branch & w_taken);

        // In reset present FETCH selects but suppress every write.
        if (rst) begin
            PCWrite   = 1'b0;
            AdrSrc    = 1'b0;
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            RegWrite  = 1'b0;
            ResultSrc = RES_ALURESULT;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ALUOp     = ALUOP_ADD;
            illegal   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero, lt;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;

    int n_vec = 0;
    int n_err = 0;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .zero(zero), .lt(lt), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ImmSrc(ImmSrc), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,illegal}
    logic [16:0] obs;
    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal};

    // Abstract per-cycle activities of an instruction, as listed in the
    // controller's state/output table.
    typedef enum {FE, DE, MADR, MRD, MWB, MWR, XR, XI, AWB, BR, JR, JL, LU} step_t;

    task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %05h want %05h", tag, got, want);
        end
    endtask

    function automatic logic [2:0] ref_imm(input logic [6:0] op);
        case (op)
            7'b0100011: return 3'b001;
            7'b1100011: return 3'b010;
            7'b1101111: return 3'b011;
            7'b0110111: return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

    function automatic bit supported(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                          7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    endfunction

    function automatic logic [16:0] pack(input logic pcw, adr, mw, irw, rw,
                                         input logic [1:0] res, a, b, aop,
                                         input logic [2:0] imm, input logic ill);
        return {pcw, adr, mw, irw, rw, res, a, b, aop, imm, ill};
    endfunction

    function automatic logic [16:0] ref_out(input step_t s, input logic [6:0] op,
                                            input logic [2:0] f3, input logic z, l);
        logic [2:0] im;
        logic tk;
        im = ref_imm(op);
        tk = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : (f3 == 3'd4) ? l : (f3 == 3'd5) ? !l : 1'b0;
        case (s)
            FE:   return pack(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, im, 0);
            DE:   return pack(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, im, !supported(op));
            MADR: return pack(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, im, 0);
            MRD:  return pack(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, im, 0);
            MWB:  return pack(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, im, 0);
            MWR:  return pack(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, im, 0);
            XR:   return pack(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, im, 0);
            XI:   return pack(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, im, 0);
            AWB:  return pack(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, im, 0);
            BR:   return pack(tk, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, im, 0);
            JR:   return pack(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, im, 0);
            JL:   return pack(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, im, 0);
            LU:   return pack(0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 2'b00, im, 0);
            default: return '0;
        endcase
    endfunction

    // Reset: FETCH selects, no write enables.
    function automatic logic [16:0] ref_rst(input logic [6:0] op);
        return pack(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, ref_imm(op), 0);
    endfunction

    // Run one instruction starting in FETCH. abort_at >= 0 asserts rst in that
    // cycle of the instruction, which must abort it.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic z, input logic l, input int abort_at);
        step_t seq[$];
        seq = '{FE, DE};
        case (op)
            7'b0000011: seq = '{FE, DE, MADR, MRD, MWB};
            7'b0100011: seq = '{FE, DE, MADR, MWR};
            7'b0110011: seq = '{FE, DE, XR, AWB};
            7'b0010011: seq = '{FE, DE, XI, AWB};
            7'b1100011: seq = '{FE, DE, BR};
            7'b1101111: seq = '{FE, DE, JL, AWB};
            7'b1100111: seq = '{FE, DE, JR, JL, AWB};
            7'b0110111: seq = '{FE, DE, LU, AWB};
            default:    seq = '{FE, DE};
        endcase
        opcode = op; funct3 = f3; zero = z; lt = l;
        for (int i = 0; i < seq.size(); i++) begin
            if (i == abort_at) rst = 1'b1;
            @(negedge clk);
            if (rst) chk($sformatf("abort op=%b c%0d", op, i), obs, ref_rst(op));
            else     chk($sformatf("op=%b f3=%0d z=%0b lt=%0b c%0d %s", op, f3, z, l, i, seq[i].name()),
                         obs, ref_out(seq[i], op, f3, z, l));
            @(posedge clk);
            #1;
            if (rst) begin
                rst = 1'b0;
                return;
            end
        end
    endtask

    logic [6:0] ops [12] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                             7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                             7'b1111111, 7'b0000000, 7'b0010111, 7'b1110011};

    initial begin
        rst = 1'b1; opcode = 7'b0110011; funct3 = 3'd0; zero = 1'b0; lt = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("reset", obs, ref_rst(opcode));
            @(posedge clk);
            #1;
        end
        rst = 1'b0;

        run_instr(7'b0110011, 3'd0, 0, 0, -1);   // R-type
        run_instr(7'b0000011, 3'd2, 0, 0, -1);   // load
        run_instr(7'b0100011, 3'd2, 0, 0, -1);   // store
        run_instr(7'b1100011, 3'd0, 1, 0, -1);   // beq taken
        run_instr(7'b1100011, 3'd1, 1, 0, -1);   // bne not taken
        run_instr(7'b1100011, 3'd5, 0, 0, -1);   // bge taken
        run_instr(7'b1100011, 3'd2, 1, 1, -1);   // unsupported funct3
        run_instr(7'b1101111, 3'd0, 0, 0, -1);   // JAL
        run_instr(7'b1100111, 3'd0, 0, 0, -1);   // JALR
        run_instr(7'b0110111, 3'd0, 0, 0, -1);   // LUI
        run_instr(7'b1111111, 3'd0, 0, 0, -1);   // illegal
        run_instr(7'b0000011, 3'd2, 0, 0, 3);    // reset during MEMREAD
        run_instr(7'b0010011, 3'd0, 0, 0, -1);   // must restart at FETCH

        for (int k = 0; k < 300; k++) begin
            logic [6:0] op;
            int ab;
            op = ops[$urandom_range(0, 11)];
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1;
            run_instr(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), ab);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
